// File: rtl/sub_bytes_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes_pkg
// Brief  : Shared AES constants: FIPS-197 S-box tables and engine state codes.
// Rev    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Tables are written in FIPS row order, so S(x) lives at element ~x.
    localparam logic [255:0][7:0] c_sbox_fwd = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [255:0][7:0] c_sbox_inv = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

endpackage
`default_nettype wire

// File: rtl/sub_bytes_seq_if.sv
`default_nettype none
// ============================================================================
// Module : sub_bytes_seq_if
// Brief  : Block handshake bundle between the SubBytes engine and its peers.
// Rev    : 1.0 - initial release
// ============================================================================
interface sub_bytes_seq_if
    import aes_pkg::*;
;
    logic                         in_valid;
    logic                         in_ready;
    logic [AES_BLOCK_BYTES*8-1:0] in_data;
    logic                         in_inv;
    logic                         out_valid;
    logic                         out_ready;
    logic [AES_BLOCK_BYTES*8-1:0] out_data;
    logic                         busy;

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/sub_bytes_seq_lane.sv
`default_nettype none
// ============================================================================
// Module : sbox_lane
// Brief  : Combinational single-byte AES S-box / inverse S-box lookup.
// Rev    : 1.0 - initial release
// ============================================================================
module sbox_lane
    import aes_pkg::*;
#(
    parameter int ENABLE_INV = 1
) (
    input  logic [7:0] i_byte,
    input  logic       i_inv,
    output logic [7:0] o_byte
);

    if (ENABLE_INV != 0) begin : g_fwd_inv
        assign o_byte = i_inv ? c_sbox_inv[~i_byte] : c_sbox_fwd[~i_byte];
    end else begin : g_fwd_only
        logic w_unused_inv;
        assign w_unused_inv = i_inv;
        assign o_byte       = c_sbox_fwd[~i_byte];
    end

endmodule
`default_nettype wire

// File: rtl/sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module : sub_bytes_seq
// Brief  : Handshaked AES SubBytes engine, LANES bytes substituted per beat.
// Rev    : 1.0 - initial release
// ============================================================================
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int ENABLE_INV = 1
) (
    input  logic           clk,
    input  logic           rst,
    sub_bytes_seq_if.slave bus
);

    localparam int c_beats = AES_BLOCK_BYTES / LANES;
    localparam int c_cnt_w = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_beats - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    state_t                       r_state;
    state_t                       w_next;
    logic [c_cnt_w-1:0]           r_beat;
    logic [AES_BLOCK_BYTES*8-1:0] r_src;
    logic [AES_BLOCK_BYTES*8-1:0] r_res;
    logic                         r_inv;
    logic                         w_in_ready;
    logic                         w_out_valid;
    logic                         w_busy;
    logic                         w_accept;
    logic [7:0]                   w_lane_in  [LANES];
    logic [7:0]                   w_lane_out [LANES];

    // Lane k works on byte beat*LANES+k, so bytes go out in ascending order.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_lane_in[k] = r_src[(32'(r_beat) * LANES + k) * 8 +: 8];

        sbox_lane #(
            .ENABLE_INV (ENABLE_INV)
        ) u_lane (
            .i_byte (w_lane_in[k]),
            .i_inv  (r_inv),
            .o_byte (w_lane_out[k])
        );
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = BUSY;
            end
            BUSY: begin
                w_busy = 1'b1;
                if (r_beat == c_last_beat) w_next = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                // Consuming and accepting in one cycle skips the IDLE bubble.
                w_in_ready  = bus.out_ready;
                if (bus.out_ready) w_next = bus.in_valid ? BUSY : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_src   <= '0;
            r_res   <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_src  <= bus.in_data;
                r_inv  <= bus.in_inv && (ENABLE_INV != 0);
                r_beat <= '0;
            end else if (r_state == BUSY) begin
                for (int k = 0; k < LANES; k++) begin
                    r_res[(32'(r_beat) * LANES + k) * 8 +: 8] <= w_lane_out[k];
                end
                if (r_beat != c_last_beat) r_beat <= r_beat + c_cnt_w'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_res;
    assign bus.busy      = w_busy;

endmodule
`default_nettype wire
